// File: rtl/bp_pkg.sv
// Shared encodings for the branch direction predictor: 2-bit counter states
// and the conditional-branch opcode.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT         = 2'b00;
    localparam ctr_t WNT         = 2'b01;
    localparam ctr_t WT          = 2'b10;
    localparam ctr_t ST          = 2'b11;
    localparam ctr_t RESET_STATE = WNT;

    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

    // The MSB of a 2-bit counter is the predicted direction.
    function automatic logic predOf(input ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/sat_cnt2.sv
// Next-state function of one 2-bit saturating direction counter.
// Pure combinational; storage lives in the predictor table.
module sat_cnt2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Untagged bimodal branch direction predictor with a saturating mispredict counter.
// Define BP_BYPASS_EN to forward a same-cycle update to the fetch lookup.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      f_pc,
    input  logic             f_is_branch,
    output logic             f_pred_taken,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    output logic             ex_mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    ctr_t                tbl [ENTRIES];
    logic [IDX_BITS-1:0] fIdx;
    logic [IDX_BITS-1:0] exIdx;
    ctr_t                exCur;
    ctr_t                exNext;
    ctr_t                fEntry;
    logic                unusedPcBits;

    // PCs are word-aligned, so bits [1:0] never select an entry.
    assign fIdx  = f_pc[IDX_BITS+1:2];
    assign exIdx = ex_pc[IDX_BITS+1:2];
    assign unusedPcBits = ^{f_pc[31:IDX_BITS+2], f_pc[1:0],
                            ex_pc[31:IDX_BITS+2], ex_pc[1:0]};

    assign exCur = tbl[exIdx];

    sat_cnt2 u_satCnt (
        .cur   (exCur),
        .taken (ex_taken),
        .nxt   (exNext)
    );

    always_comb begin
        fEntry = tbl[fIdx];
`ifdef BP_BYPASS_EN
        // Reset wins over forwarding so the lookup stays not-taken while rst is held.
        if (ex_valid && !rst && (exIdx == fIdx)) fEntry = exNext;
`endif
    end

    assign f_pred_taken  = f_is_branch & predOf(fEntry);
    assign ex_mispredict = ex_valid & (ex_taken != ex_pred_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) tbl[i] <= RESET_STATE;
        end else if (ex_valid) begin
            tbl[exIdx] <= exNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (ex_mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default 64-entry build plus
// a 4-bit mispredict-counter instance for saturation).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic        f_is_branch;
    logic        f_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic        ex_mispredict;
    logic [15:0] mispredict_cnt;

    logic        sValid, sTaken, sPredTaken;
    logic        sFPred, sMispredict;
    logic [3:0]  sCnt;

    int nAssert = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(6), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .f_pc           (f_pc),
        .f_is_branch    (f_is_branch),
        .f_pred_taken   (f_pred_taken),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_pred_taken  (ex_pred_taken),
        .ex_mispredict  (ex_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    branch_predictor #(.IDX_BITS(6), .CNT_W(4)) dutSmall (
        .clk            (clk),
        .rst            (rst),
        .f_pc           (f_pc),
        .f_is_branch    (f_is_branch),
        .f_pred_taken   (sFPred),
        .ex_valid       (sValid),
        .ex_pc          (32'h0000_0020),
        .ex_taken       (sTaken),
        .ex_pred_taken  (sPredTaken),
        .ex_mispredict  (sMispredict),
        .mispredict_cnt (sCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One correctly-predicted resolving branch; trains without counting a mispredict.
    task automatic upd(input logic [31:0] pc, input logic t);
        ex_valid = 1'b1; ex_pc = pc; ex_taken = t; ex_pred_taken = t;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp);
        f_pc = pc; f_is_branch = 1'b1;
        #1;
        chk(tag, f_pred_taken, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bypassExp;
        rst = 1'b1;
        f_pc = '0; f_is_branch = 1'b0;
        ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
        sValid = 1'b0; sTaken = 1'b0; sPredTaken = 1'b0;
        #2;

        for (int i = 0; i < 64; i++) look("reset_sweep", 32'(i) << 2, 1'b0);
        chk("reset_cnt", mispredict_cnt, 16'd0);
        ex_valid = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        #1;
        chk("mispredict_during_rst", ex_mispredict, 1'b1);
        ex_valid = 1'b0; ex_taken = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("cnt_after_rst_release", mispredict_cnt, 16'd0);

        f_pc = 32'h100; f_is_branch = 1'b0;
        #1;
        chk("not_branch_forces_0", f_pred_taken, 1'b0);

        // Training at 0x100 (index 0): 01 -> 10 -> 11 -> 11 -> 11 -> 10 -> 01
        upd(32'h100, 1'b1); look("train_t1", 32'h100, 1'b1);
        upd(32'h100, 1'b1); look("train_t2", 32'h100, 1'b1);
        upd(32'h100, 1'b1);
        upd(32'h100, 1'b1); look("train_t4", 32'h100, 1'b1);
        upd(32'h100, 1'b0); look("train_nt1", 32'h100, 1'b1);
        upd(32'h100, 1'b0); look("train_nt2", 32'h100, 1'b0);

        // Floor saturation at 0x40 (index 16)
        for (int i = 0; i < 5; i++) upd(32'h40, 1'b0);
        look("snt_floor", 32'h40, 1'b0);
        upd(32'h40, 1'b1); look("snt_then_t1", 32'h40, 1'b0);
        upd(32'h40, 1'b1); look("snt_then_t2", 32'h40, 1'b1);

        // Aliasing: 0x000 and 0x100 share index 0; 0x004 is index 1
        upd(32'h000, 1'b1);
        upd(32'h000, 1'b1);
        look("alias_0x100", 32'h100, 1'b1);
        look("alias_0x004", 32'h004, 1'b0);

        // ex_valid=0 must not train index 2
        ex_valid = 1'b0; ex_pc = 32'h8; ex_taken = 1'b1; ex_pred_taken = 1'b1;
        tick(); tick();
        look("no_update_when_invalid", 32'h8, 1'b0);
        chk("cnt_no_mispredicts_yet", mispredict_cnt, 16'd0);

        // Mispredict counting on index 3
        ex_pc = 32'hC; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1'b1;
            #1;
            chk("mispredict_flag", ex_mispredict, 1'b1);
            tick();
        end
        ex_valid = 1'b0;
        #1;
        chk("mispredict_cnt_3", mispredict_cnt, 16'd3);
        chk("mispredict_invalid", ex_mispredict, 1'b0);
        ex_valid = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b1;
        #1;
        chk("correct_pred_no_flag", ex_mispredict, 1'b0);
        ex_taken = 1'b0; ex_pred_taken = 1'b1;
        #1;
        chk("mispredict_nt_flag", ex_mispredict, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("mispredict_cnt_4", mispredict_cnt, 16'd4);

        // 4-bit counter saturates at 15
        sValid = 1'b1; sTaken = 1'b1; sPredTaken = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("small_cnt_14", sCnt, 4'd14);
        tick();
        chk("small_cnt_15", sCnt, 4'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("small_cnt_hold", sCnt, 4'd15);
        sValid = 1'b0;

        // Same-cycle update and lookup on index 4 (entry 01)
`ifdef BP_BYPASS_EN
        bypassExp = 1'b1;
`else
        bypassExp = 1'b0;
`endif
        f_pc = 32'h10; f_is_branch = 1'b1;
        ex_valid = 1'b1; ex_pc = 32'h10; ex_taken = 1'b1; ex_pred_taken = 1'b1;
        #1;
        chk("conflict_same_cycle", f_pred_taken, bypassExp);
        look("conflict_other_idx", 32'h14, 1'b0);
        f_pc = 32'h10;
        tick();
        ex_valid = 1'b0;
        look("conflict_next_cycle", 32'h10, 1'b1);

        // Reset mid-update: index 4 is at 10, pending taken update is discarded
        ex_valid = 1'b1; ex_pc = 32'h10; ex_taken = 1'b1; ex_pred_taken = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        look("rst_mid_immediate", 32'h10, 1'b0);
        tick();
        ex_valid = 1'b0;
        look("rst_mid_held", 32'h10, 1'b0);
        chk("rst_mid_cnt", mispredict_cnt, 16'd0);
        rst = 1'b0;
        look("rst_idx0_back_to_wnt", 32'h0, 1'b0);
        upd(32'h10, 1'b1);
        look("rst_entry_was_wnt", 32'h10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
